// File: rtl/sub_bytes_serial_if.sv
// Word-level handshake bundle for sub_bytes_serial: an input word/key stream and a result stream.
// The producer/consumer side uses master; the substitution stage uses slave.
interface sub_bytes_serial_if #(
    parameter int NBYTES = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   in_state;
    logic [8*NBYTES-1:0]   in_key;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   out_state;

    modport master (
        output in_valid, in_state, in_key, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, in_key, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/sub_bytes_serial.sv
// Byte-serial S-box substitution plus round-key add, feeding an external combinational S-box.
// One word is captured, its bytes are substituted one per cycle, and the assembled result is held.
module sub_bytes_serial #(
    parameter int NBYTES = 16,
    parameter int IDX_W  = 5
) (
    input  logic                clk,
    input  logic                rst,
    sub_bytes_serial_if.slave   bus,
    output logic [7:0]          sbox_sel,
    input  logic [7:0]          sbox_data,
    output logic                busy
);
    localparam int SEL_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } fsm_t;

    fsm_t                    state;
    fsm_t                    state_nxt;
    logic [IDX_W-1:0]        idx;
    logic [SEL_W-1:0]        sel;
    logic                    last;
    logic [NBYTES-1:0][7:0]  state_reg;
    logic [NBYTES-1:0][7:0]  key_reg;
    logic [NBYTES-1:0][7:0]  result;

    // idx never exceeds NBYTES-1, so its low bits address the byte arrays directly.
    assign sel  = idx[SEL_W-1:0];
    assign last = (idx == LAST_IDX);

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: next state is defaulted first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = SUB;
            SUB:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            state_reg <= '0;
            key_reg   <= '0;
            result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_reg <= bus.in_state;
                        key_reg   <= bus.in_key;
                        idx       <= '0;
                    end
                end
                SUB: begin
                    result[sel] <= sbox_data ^ key_reg[sel];
                    idx         <= last ? '0 : idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_state = result;
    assign busy          = (state != IDLE);
    assign sbox_sel      = (state == SUB) ? state_reg[sel] : 8'h00;
endmodule

// File: tb/tb_sub_bytes_serial.sv
// Directed bench for sub_bytes_serial with S(x)=~x; expected words are pushed at accept time
// and a negedge monitor pops and compares them on every output handshake.
module tb_sub_bytes_serial;
    localparam int NBYTES = 16;
    localparam int W      = 8 * NBYTES;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sbox_sel;
    logic [7:0] sbox_data;
    logic       busy;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [W-1:0] exp_q[$];

    sub_bytes_serial_if #(.NBYTES(NBYTES)) bus ();

    sub_bytes_serial #(.NBYTES(NBYTES), .IDX_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .sbox_sel  (sbox_sel),
        .sbox_data (sbox_data),
        .busy      (busy)
    );

    // Stand-in for S_BOX_GF.
    assign sbox_data = ~sbox_sel;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("unexpected output", bus.out_state, 'x);
            else                   check("out_state", bus.out_state, exp_q.pop_front());
        end
    end

    task automatic accept(input logic [W-1:0] s, input logic [W-1:0] k, input logic [W-1:0] exp,
                          input bit push, input bit hold, output int c);
        bus.in_valid = 1'b1;
        bus.in_state = s;
        bus.in_key   = k;
        for (int i = 0; i < 50 && !bus.in_ready; i++) begin
            @(posedge clk); #1;
        end
        check("in_ready before accept", W'(bus.in_ready), W'(1));
        if (push) exp_q.push_back(exp);
        @(posedge clk); #1;
        c = cyc;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    // Starts #1 after the accept edge: checks sbox_sel over 16 SUB cycles, then out_valid.
    task automatic sub_walk(input logic [W-1:0] s);
        for (int i = 0; i < NBYTES; i++) begin
            check($sformatf("sbox_sel[%0d]", i), W'(sbox_sel), W'(s[8*i +: 8]));
            if (i == 0) check("out_valid low in SUB", W'(bus.out_valid), W'(0));
            @(posedge clk); #1;
        end
        check("out_valid after NBYTES", W'(bus.out_valid), W'(1));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && !bus.out_valid; i++) begin
            @(posedge clk); #1;
        end
        check("out_valid wait", W'(bus.out_valid), W'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        int c0, c1;
        logic [W-1:0] s_inc, s_mix;
        s_inc = 128'h0F0E0D0C0B0A09080706050403020100;
        s_mix = 128'h0123456789ABCDEFFEDCBA9876543210;

        bus.in_valid  = 1'b0;
        bus.in_state  = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset in_ready", W'(bus.in_ready), W'(1));
        check("reset out_valid", W'(bus.out_valid), W'(0));
        check("reset busy", W'(busy), W'(0));
        check("reset sbox_sel", W'(sbox_sel), W'(0));
        check("reset out_state", bus.out_state, '0);

        // 1: key 0 gives the inverted state; latency and sel order checked along the way.
        accept(s_inc, '0, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF, 1'b1, 1'b0, c0);
        check("busy in SUB", W'(busy), W'(1));
        sub_walk(s_inc);
        @(posedge clk); #1;
        check("idle after handshake", W'(bus.in_ready), W'(1));

        // 2: all-FF key cancels the inversion.
        accept(s_inc, {W{1'b1}}, s_inc, 1'b1, 1'b0, c0);
        sub_walk(s_inc);
        @(posedge clk); #1;

        // 3: backpressure in DONE.
        bus.out_ready = 1'b0;
        accept(s_mix, {{64{1'b0}}, {64{1'b1}}}, 128'hFEDCBA9876543210FEDCBA9876543210, 1'b1, 1'b0, c0);
        sub_walk(s_mix);
        for (int i = 0; i < 5; i++) begin
            check("held out_valid", W'(bus.out_valid), W'(1));
            check("held in_ready", W'(bus.in_ready), W'(0));
            check("held out_state", bus.out_state, 128'hFEDCBA9876543210FEDCBA9876543210);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("idle after release", W'(bus.in_ready), W'(1));
        check("out_valid after release", W'(bus.out_valid), W'(0));

        // 4: input bus churn during SUB is ignored.
        accept(128'hDEADBEEF00000000FFFFFFFF12345678, '0,
               128'h21524110FFFFFFFF00000000EDCBA987, 1'b1, 1'b0, c0);
        for (int i = 0; i < NBYTES - 1; i++) begin
            bus.in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk); #1;
        end
        wait_done();

        // 5: reset in the 7th SUB cycle discards the word.
        accept(s_inc, '0, '0, 1'b0, 1'b0, c0);
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst in_ready", W'(bus.in_ready), W'(1));
        check("rst out_valid", W'(bus.out_valid), W'(0));
        check("rst out_state", bus.out_state, '0);
        check("rst sbox_sel", W'(sbox_sel), W'(0));
        accept(s_inc, {NBYTES{8'h01}}, 128'hF1F0F3F2F5F4F7F6F9F8FBFAFDFCFFFE, 1'b1, 1'b0, c0);
        wait_done();

        // 6: back-to-back with in_valid held high.
        accept(s_inc, '0, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF, 1'b1, 1'b1, c0);
        bus.in_state = s_mix;
        bus.in_key   = {W{1'b1}};
        accept(s_mix, {W{1'b1}}, s_mix, 1'b1, 1'b0, c1);
        check("accept spacing", W'(c1 - c0), W'(NBYTES + 2));
        wait_done();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard drained", W'(exp_q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
